score_controller: RTL

//  Sequences all score updates for the score display path.
//  - Collects one-cycle award events (gold, diamond, monster kill) into per-source pending counters.
//  - Serialises the pending awards through one shared digit-serial BCD adder.
//  - Publishes a 6-digit BCD score atomically. The score bitmap renderer therefore never sees a partial sum.
//  - Sits between game logic (eat/kill pulses) and the score bitmap/rectangle drawing blocks.

---
 rtl/score_controller.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/score_controller.sv
// -----------------------------------------------------------------------------
// score_controller
//
// Sequences every score update for the score display path. One-cycle award
// pulses (gold, diamond, monster kill) are collected into per-source pending
// counters. They are then serialised through one shared digit-serial BCD
// adder, and the 6-digit BCD score is published atomically, so the bitmap
// renderer never sees a partial sum.
//
// FSM: IDLE -> ADD (6 cycles, one BCD digit each) -> COMMIT -> IDLE.
// This gives one commit per 8 clocks when awards are queued back to back.
//
// Configuration macro:
//   SCORE_EXTRA_LIFE_EN  When defined, extra_life pulses for one cycle at any
//                        commit that changes digits[23:16], which is once per
//                        10000-point boundary crossed. When undefined,
//                        extra_life is tied to 0.
//
// Ports:
//   clk                  in   1   system clock
//   resetN               in   1   asynchronous active-low reset
//   clear_score          in   1   synchronous new-game clear (highest priority)
//   player_eat_gold      in   1   one-cycle award pulse, GOLD_PTS
//   player_eat_dimond    in   1   one-cycle award pulse, DIAMOND_PTS
//   player_kill_monster  in   1   one-cycle award pulse, MONSTER_PTS
//   score_digits         out  24  committed score, 6 BCD digits, [3:0] = units
//   busy                 out  1   high in any state other than IDLE
//   pend_overflow        out  1   sticky: pulse dropped on a saturated counter
//   extra_life           out  1   one-cycle pulse (SCORE_EXTRA_LIFE_EN only)
// -----------------------------------------------------------------------------
module score_controller #(
    parameter logic [23:0] GOLD_PTS    = 24'h000500,
    parameter logic [23:0] DIAMOND_PTS = 24'h000025,
    parameter logic [23:0] MONSTER_PTS = 24'h000250,
    parameter int unsigned PEND_W      = 3
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        clear_score,
    input  logic        player_eat_gold,
    input  logic        player_eat_dimond,
    input  logic        player_kill_monster,
    output logic [23:0] score_digits,
    output logic        busy,
    output logic        pend_overflow,
    output logic        extra_life
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADD    = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // Source indices into the pending-counter array and the pulse/grant vectors.
    localparam int SRC_GOLD    = 0;
    localparam int SRC_DIAMOND = 1;
    localparam int SRC_MONSTER = 2;

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_e            state_q,  state_d;
    logic [PEND_W-1:0] pend_q[3];
    logic [PEND_W-1:0] pend_d[3];
    logic [23:0]       work_q,   work_d;
    logic [23:0]       addend_q, addend_d;
    logic [23:0]       score_q,  score_d;
    logic [2:0]        idx_q,    idx_d;
    logic              carry_q,  carry_d;
    logic              ovf_q,    ovf_d;

    logic [2:0]        pulse_s;
    logic [2:0]        grant_s;
    logic [4:0]        sum_s;
    logic [3:0]        digit_s;

    assign pulse_s = {player_kill_monster, player_eat_dimond, player_eat_gold};

    // NOTE: every signal driven here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        work_d   = work_q;
        addend_d = addend_q;
        score_d  = score_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        grant_s  = '0;
        sum_s    = '0;
        digit_s  = '0;

        unique case (state_q)
            IDLE: begin
                // Fixed priority: diamond > monster > gold.
                if (pend_q[SRC_DIAMOND] != '0)      grant_s[SRC_DIAMOND] = 1'b1;
                else if (pend_q[SRC_MONSTER] != '0) grant_s[SRC_MONSTER] = 1'b1;
                else if (pend_q[SRC_GOLD] != '0)    grant_s[SRC_GOLD]    = 1'b1;

                if (grant_s != '0) begin
                    state_d  = ADD;
                    work_d   = score_q;
                    idx_d    = '0;
                    carry_d  = 1'b0;
                    addend_d = grant_s[SRC_DIAMOND] ? DIAMOND_PTS :
                               grant_s[SRC_MONSTER] ? MONSTER_PTS : GOLD_PTS;
                end
            end

            ADD: begin
                sum_s = {1'b0, work_q[{idx_q, 2'b00} +: 4]}
                      + {1'b0, addend_q[{idx_q, 2'b00} +: 4]}
                      + {4'b0000, carry_q};
                // s is at most 19, so s - 10 fits in the low nibble modulo 16.
                if (sum_s > 5'd9) begin
                    digit_s = sum_s[3:0] - 4'd10;
                    carry_d = 1'b1;
                end else begin
                    digit_s = sum_s[3:0];
                    carry_d = 1'b0;
                end
                work_d[{idx_q, 2'b00} +: 4] = digit_s;
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd5) state_d = COMMIT;
            end

            COMMIT: begin
                // A carry out of digit 5 means the sum passed 999999.
                score_d = carry_q ? 24'h999999 : work_q;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        // A pulse and a grant on the same source cancel; the pulse is not lost,
        // so it does not count as an overflow even on a saturated counter.
        for (int i = 0; i < 3; i++) begin
            if (pulse_s[i] && !grant_s[i]) begin
                if (pend_q[i] == PEND_MAX) ovf_d = 1'b1;
                else                       pend_d[i] = pend_q[i] + PEND_W'(1);
            end else if (!pulse_s[i] && grant_s[i]) begin
                pend_d[i] = pend_q[i] - PEND_W'(1);
            end
        end

        // New-game clear overrides everything, including same-cycle pulses and
        // an add in flight.
        if (clear_score) begin
            state_d = IDLE;
            score_d = '0;
            ovf_d   = 1'b0;
            for (int i = 0; i < 3; i++) pend_d[i] = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every
    // always_ff samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            work_q   <= '0;
            addend_q <= '0;
            score_q  <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < 3; i++) pend_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            addend_q <= addend_d;
            score_q  <= score_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            pend_q   <= pend_d;
        end
    end

    assign score_digits  = score_q;
    assign busy          = (state_q != IDLE);
    assign pend_overflow = ovf_q;

`ifdef SCORE_EXTRA_LIFE_EN
    logic life_q, life_d;

    // The pulse lands on the COMMIT edge, alongside the new score. A clear in
    // that cycle, or a saturated score that stays unchanged, gives no pulse.
    always_comb begin
        life_d = (state_q == COMMIT) && !clear_score &&
                 (score_d[23:16] != score_q[23:16]);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) life_q <= 1'b0;
        else         life_q <= life_d;
    end

    assign extra_life = life_q;
`else
    assign extra_life = 1'b0;
`endif

endmodule
